// File: rtl/jpeg_dequant_reorder_if.sv
// rtl/jpeg_dequant_reorder_if.sv - coefficient-in / raster-sample-out bus of the dequantiser
interface jpeg_dequant_reorder_if #(parameter int OUT_W = 16);
  logic                    coeff_valid;
  logic [5:0]              coeff_index;
  logic signed [11:0]      coeff_value;
  logic                    block_done;
  logic                    dc_clear;
  logic                    qt_wr_en;
  logic [5:0]              qt_wr_addr;
  logic [7:0]              qt_wr_data;
  logic                    blk_ready;
  logic                    overflow;
  logic                    out_valid;
  logic                    out_ready;
  logic [5:0]              out_index;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_last;

  modport master (
    output coeff_valid, coeff_index, coeff_value, block_done, dc_clear,
    output qt_wr_en, qt_wr_addr, qt_wr_data, out_ready,
    input  blk_ready, overflow, out_valid, out_index, out_data, out_last
  );

  modport slave (
    input  coeff_valid, coeff_index, coeff_value, block_done, dc_clear,
    input  qt_wr_en, qt_wr_addr, qt_wr_data, out_ready,
    output blk_ready, overflow, out_valid, out_index, out_data, out_last
  );
endinterface

// File: rtl/jpeg_dequant_reorder.sv
// rtl/jpeg_dequant_reorder.sv - DC prediction, quant scaling and zigzag-to-raster reorder
// into two ping-pong 8x8 banks, drained one block at a time.
module jpeg_dequant_reorder #(
  parameter int OUT_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  jpeg_dequant_reorder_if.slave  bus
);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_t;
  typedef enum logic {D_IDLE, D_RUN} drn_st_t;

  localparam logic [5:0] ZZ2NAT [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  localparam int MAX_OUT = (1 << (OUT_W - 1)) - 1;
  localparam int MIN_OUT = -(1 << (OUT_W - 1));
  localparam logic signed [20:0] P_MAX = 21'(MAX_OUT);
  localparam logic signed [20:0] P_MIN = 21'(MIN_OUT);

  logic [7:0]              qt [64];
  logic signed [11:0]      dc_pred;
  logic signed [12:0]      dc_sum;
  logic signed [11:0]      dc_sat;

  logic                    s1_valid;
  logic                    s1_done;
  logic [5:0]              s1_nat;
  logic [7:0]              s1_q;
  logic signed [11:0]      s1_v;
  logic signed [20:0]      prod;
  logic signed [OUT_W-1:0] prod_sat;

  bank_st_t                bank_st [2];
  logic [63:0]             mask [2];
  logic signed [OUT_W-1:0] bank_data [2][64];
  logic                    fill_ptr;
  logic                    drain_ptr;
  logic                    fill_ok;
  logic                    overflow_q;

  drn_st_t                 drn_state;
  drn_st_t                 drn_next;
  logic [6:0]              rd_cnt;
  logic                    start_drain;
  logic                    chain_drain;
  logic                    load;
  logic                    last_xfer;

  logic                    out_valid_q;
  logic [5:0]              out_index_q;
  logic signed [OUT_W-1:0] out_data_q;
  logic                    out_last_q;

  // dc_clear alongside the DC term means the prediction restarts from zero
  always_comb begin
    dc_sum = (bus.dc_clear ? 13'sd0 : {dc_pred[11], dc_pred})
           + {bus.coeff_value[11], bus.coeff_value};
    if (dc_sum > 13'sd2047) begin
      dc_sat = {1'b0, {11{1'b1}}};
    end else if (dc_sum < -13'sd2048) begin
      dc_sat = {1'b1, 11'd0};
    end else begin
      dc_sat = dc_sum[11:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) qt[i] <= 8'd1;
    end else if (bus.qt_wr_en) begin
      qt[bus.qt_wr_addr] <= bus.qt_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_done  <= 1'b0;
      s1_nat   <= '0;
      s1_q     <= '0;
      s1_v     <= '0;
      dc_pred  <= '0;
    end else begin
      s1_valid <= bus.coeff_valid;
      s1_done  <= bus.block_done;
      s1_nat   <= ZZ2NAT[bus.coeff_index];
      s1_q     <= qt[bus.coeff_index];
      s1_v     <= (bus.coeff_index == 6'd0) ? dc_sat : bus.coeff_value;
      if (bus.coeff_valid && bus.coeff_index == 6'd0) begin
        dc_pred <= dc_sat;
      end else if (bus.dc_clear) begin
        dc_pred <= '0;
      end
    end
  end

  always_comb begin
    prod = s1_v * $signed({1'b0, s1_q});
    if (prod > P_MAX) begin
      prod_sat = P_MAX[OUT_W-1:0];
    end else if (prod < P_MIN) begin
      prod_sat = P_MIN[OUT_W-1:0];
    end else begin
      prod_sat = prod[OUT_W-1:0];
    end
  end

  assign fill_ok = (bank_st[fill_ptr] == B_EMPTY) || (bank_st[fill_ptr] == B_FILLING);

  // sample storage needs no reset: the written masks gate every read
  always_ff @(posedge clk) begin
    if (s1_valid && fill_ok) begin
      bank_data[fill_ptr][s1_nat] <= prod_sat;
    end
  end

  // fill and drain always address different banks, so their updates never collide
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0] <= B_EMPTY;
      bank_st[1] <= B_EMPTY;
      mask[0]    <= '0;
      mask[1]    <= '0;
      fill_ptr   <= 1'b0;
      drain_ptr  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (fill_ok) begin
        if (s1_valid) mask[fill_ptr][s1_nat] <= 1'b1;
        if (s1_done) begin
          bank_st[fill_ptr] <= B_FULL;
          fill_ptr          <= ~fill_ptr;
        end else if (s1_valid) begin
          bank_st[fill_ptr] <= B_FILLING;
        end
      end else if (s1_valid || s1_done) begin
        overflow_q <= 1'b1;
      end
      if (start_drain) bank_st[drain_ptr] <= B_DRAINING;
      if (last_xfer) begin
        bank_st[drain_ptr] <= B_EMPTY;
        mask[drain_ptr]    <= '0;
        drain_ptr          <= ~drain_ptr;
        if (chain_drain) bank_st[~drain_ptr] <= B_DRAINING;
      end
    end
  end

  always_comb begin
    drn_next    = drn_state;
    start_drain = 1'b0;
    chain_drain = 1'b0;
    load        = 1'b0;
    last_xfer   = out_valid_q && bus.out_ready && out_last_q;
    case (drn_state)
      D_IDLE: begin
        if (bank_st[drain_ptr] == B_FULL) begin
          start_drain = 1'b1;
          drn_next    = D_RUN;
        end
      end
      D_RUN: begin
        load = !rd_cnt[6] && (!out_valid_q || bus.out_ready);
        if (last_xfer) begin
          if (bank_st[~drain_ptr] == B_FULL) begin
            chain_drain = 1'b1;
          end else begin
            drn_next = D_IDLE;
          end
        end
      end
      default: drn_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drn_state   <= D_IDLE;
      rd_cnt      <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      drn_state <= drn_next;
      if (start_drain || chain_drain) begin
        rd_cnt <= '0;
      end else if (load) begin
        rd_cnt <= rd_cnt + 7'd1;
      end
      if (load) begin
        out_valid_q <= 1'b1;
        out_index_q <= rd_cnt[5:0];
        out_data_q  <= mask[drain_ptr][rd_cnt[5:0]] ? bank_data[drain_ptr][rd_cnt[5:0]] : '0;
        out_last_q  <= (rd_cnt[5:0] == 6'd63);
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign bus.blk_ready = fill_ok;
  assign bus.overflow  = overflow_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_index = out_index_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_jpeg_dequant_reorder.sv
// tb/tb_jpeg_dequant_reorder.sv - table-driven scoreboard bench for jpeg_dequant_reorder
module tb_jpeg_dequant_reorder;
  localparam int OUT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jpeg_dequant_reorder_if #(.OUT_W(OUT_W)) bus ();
  jpeg_dequant_reorder #(.OUT_W(OUT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int  idx;
    int  data;
    bit  last;
  } exp_t;

  typedef struct {
    bit cb, cw, ua, ub;
    int za, va, zb, vb, qa, qv, na, ea, nb, eb;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[15];
  int   zz2nat[64];
  int   errors = 0;
  int   checks = 0;
  bit   rand_mode = 1'b0;

  logic             stall_seen = 1'b0;
  logic [5:0]       st_idx;
  logic [OUT_W-1:0] st_data;
  logic             st_last;

  function automatic vec_t mk(input bit cb, input bit cw, input bit ua, input bit ub,
                              input int za, input int va, input int zb, input int vb,
                              input int qa, input int qv, input int na, input int ea,
                              input int nb, input int eb);
    vec_t v;
    v.cb = cb; v.cw = cw; v.ua = ua; v.ub = ub;
    v.za = za; v.va = va; v.zb = zb; v.vb = vb;
    v.qa = qa; v.qv = qv; v.na = na; v.ea = ea; v.nb = nb; v.eb = eb;
    return v;
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        checks++;
        if (!bus.out_valid || bus.out_index != st_idx || bus.out_data != st_data ||
            bus.out_last != st_last) begin
          errors++;
          $display("FAIL hold got v=%0b i=%0d d=%0d l=%0b want v=1 i=%0d d=%0d l=%0b",
                   bus.out_valid, bus.out_index, bus.out_data, bus.out_last,
                   st_idx, $signed(st_data), st_last);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out got i=%0d d=%0d want none", bus.out_index, bus.out_data);
        end else begin
          e = sb.pop_front();
          if (int'(bus.out_index) != e.idx || int'(bus.out_data) != e.data ||
              bus.out_last != e.last) begin
            errors++;
            $display("FAIL sample got i=%0d d=%0d l=%0b want i=%0d d=%0d l=%0b",
                     bus.out_index, bus.out_data, bus.out_last, e.idx, e.data, e.last);
          end
        end
      end
      stall_seen = bus.out_valid && !bus.out_ready;
      st_idx     = bus.out_index;
      st_data    = bus.out_data;
      st_last    = bus.out_last;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #800000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic push_block(input int e[64]);
    exp_t x;
    for (int i = 0; i < 64; i++) begin
      x.idx = i; x.data = e[i]; x.last = (i == 63);
      sb.push_back(x);
    end
  endtask

  task automatic wait_ready();
    tick();
    tick();
    for (int i = 0; i < 400 && !bus.blk_ready; i++) tick();
    check("blk_ready_wait", int'(bus.blk_ready), 1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000 && sb.size() != 0; i++) tick();
    check(name, sb.size(), 0);
  endtask

  task automatic send_coeff(input int zz, input int val, input bit clr, input bit done);
    bus.coeff_valid = 1'b1;
    bus.coeff_index = 6'(zz);
    bus.coeff_value = 12'(val);
    bus.dc_clear    = clr;
    bus.block_done  = done;
    tick();
    bus.coeff_valid = 1'b0;
    bus.dc_clear    = 1'b0;
    bus.block_done  = 1'b0;
  endtask

  task automatic send_vec(input vec_t v);
    int e[64];
    for (int i = 0; i < 64; i++) e[i] = 0;
    if (v.ua) e[v.na] = v.ea;
    if (v.ub) e[v.nb] = v.eb;
    wait_ready();
    push_block(e);
    bus.qt_wr_en   = 1'b1;
    bus.qt_wr_addr = 6'(v.qa);
    bus.qt_wr_data = 8'(v.qv);
    tick();
    bus.qt_wr_en = 1'b0;
    if (v.cb) begin
      bus.dc_clear = 1'b1;
      tick();
      bus.dc_clear = 1'b0;
    end
    if (v.ua) send_coeff(v.za, v.va, v.cw, 1'b0);
    if (v.ub) begin
      send_coeff(v.zb, v.vb, 1'b0, 1'b1);
    end else begin
      bus.block_done = 1'b1;
      tick();
      bus.block_done = 1'b0;
    end
  endtask

  initial begin
    int e[64];
    int r, c;
    bus.coeff_valid = 1'b0; bus.coeff_index = '0; bus.coeff_value = '0;
    bus.block_done = 1'b0; bus.dc_clear = 1'b0;
    bus.qt_wr_en = 1'b0; bus.qt_wr_addr = '0; bus.qt_wr_data = '0;
    bus.out_ready = 1'b1;

    r = 0; c = 0;
    for (int k = 0; k < 64; k++) begin
      zz2nat[k] = r * 8 + c;
      if ((r + c) % 2 == 0) begin
        if (c == 7) r++; else if (r == 0) c++; else begin r--; c++; end
      end else begin
        if (r == 7) c++; else if (c == 0) r++; else begin r++; c--; end
      end
    end

    vecs[0]  = mk(0,1,1,1,  0,5,      1,-3,  0,1,    0,5,      1,-3);
    vecs[1]  = mk(0,0,1,0,  0,2,      0,0,   0,1,    0,7,      0,0);
    vecs[2]  = mk(1,0,1,0,  0,4,      0,0,   0,1,    0,4,      0,0);
    vecs[3]  = mk(0,1,1,0,  0,9,      0,0,   0,1,    0,9,      0,0);
    vecs[4]  = mk(0,1,1,1,  0,3,      2,-7,  2,10,   0,3,      8,-70);
    vecs[5]  = mk(0,0,1,0,  1,2047,   0,0,   1,255,  1,32767,  0,0);
    vecs[6]  = mk(0,0,1,0,  1,-2048,  0,0,   1,255,  1,-32768, 0,0);
    vecs[7]  = mk(0,1,1,0,  0,2047,   0,0,   0,1,    0,2047,   0,0);
    vecs[8]  = mk(0,0,1,0,  0,5,      0,0,   0,1,    0,2047,   0,0);
    vecs[9]  = mk(0,1,1,1,  0,-2048,  0,-1,  0,1,    0,-2048,  0,-2048);
    vecs[10] = mk(0,0,1,1,  5,1,      5,-4,  5,1,    2,1,      2,-4);
    vecs[11] = mk(0,0,1,0,  63,100,   0,0,   63,3,   63,300,   0,0);
    vecs[12] = mk(0,0,1,0,  10,-1,    0,0,   10,2,   32,-2,    0,0);
    vecs[13] = mk(0,0,0,0,  0,0,      0,0,   4,1,    0,0,      0,0);
    vecs[14] = mk(0,1,1,1,  0,100,    1,-100, 0,200, 0,20000,  1,-25500);

    tick(); tick(); tick();
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_blk_ready", int'(bus.blk_ready), 1);
    check("rst_overflow",  int'(bus.overflow), 0);
    check("rst_out_last",  int'(bus.out_last), 0);
    check("rst_out_index", int'(bus.out_index), 0);
    check("rst_out_data",  int'(bus.out_data), 0);
    rst = 1'b0;
    tick();

    wait_ready();
    for (int k = 0; k < 64; k++) e[zz2nat[k]] = k + 1;
    push_block(e);
    for (int k = 0; k < 64; k++) send_coeff(k, k + 1, k == 0, k == 63);
    wait_drain("zigzag_sweep");

    rand_mode = 1'b1;
    for (int i = 0; i < 15; i++) send_vec(vecs[i]);
    wait_drain("table_drain");

    wait_ready();
    for (int i = 0; i < 64; i++) e[i] = 0;
    e[16] = 2;
    push_block(e);
    bus.qt_wr_en = 1'b1; bus.qt_wr_addr = 6'd3; bus.qt_wr_data = 8'd50;
    send_coeff(3, 2, 1'b0, 1'b1);
    bus.qt_wr_en = 1'b0;
    send_vec(mk(0,0,1,0, 3,2, 0,0, 3,50, 16,100, 0,0));
    wait_drain("qt_coincident_drain");

    rand_mode = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    send_vec(mk(0,1,1,0, 0,1, 0,0, 0,1, 0,1, 0,0));
    send_vec(mk(0,0,1,0, 1,3, 0,0, 1,255, 1,765, 0,0));
    tick(); tick(); tick();
    check("stall_blk_ready", int'(bus.blk_ready), 0);
    check("stall_no_overflow", int'(bus.overflow), 0);
    send_coeff(2, 5, 1'b0, 1'b0);
    tick(); tick();
    check("stall_overflow", int'(bus.overflow), 1);
    check("stall_out_valid", int'(bus.out_valid), 1);
    check("stall_out_index", int'(bus.out_index), 0);
    bus.out_ready = 1'b1;
    wait_drain("stall_drain");
    tick(); tick();
    check("post_stall_blk_ready", int'(bus.blk_ready), 1);
    check("overflow_sticky", int'(bus.overflow), 1);

    send_vec(mk(0,1,1,0, 0,6, 0,0, 0,1, 0,6, 0,0));
    wait_drain("dc_only_drain");
    send_vec(mk(0,0,1,0, 0,10, 0,0, 0,1, 0,16, 0,0));
    for (int i = 0; i < 12; i++) tick();
    rst = 1'b1;
    tick();
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_blk_ready", int'(bus.blk_ready), 1);
    check("midrst_overflow", int'(bus.overflow), 0);
    sb.delete();
    rst = 1'b0;
    tick();
    send_vec(mk(0,0,1,1, 0,3, 1,3, 4,1, 0,3, 1,3));
    wait_drain("post_rst_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
